// File: rtl/register_tree_pkg.sv
// Shared node record and priority compare for the register-tree priority queue.
// Node fields are sized to the widest supported key/payload; instances use the low bits.
package register_tree_pkg;
    localparam int KEY_W_MAX = 64;
    localparam int VAL_W_MAX = 64;

    typedef struct packed {
        logic                 valid;
        logic [KEY_W_MAX-1:0] key;
        logic [VAL_W_MAX-1:0] val;
    } rt_node_t;

    // True when a strictly outranks b; ties never outrank, so equal keys stay put.
    function automatic logic rt_outranks(rt_node_t a, rt_node_t b, bit min_mode);
        if (a.valid != b.valid) return a.valid;
        if (!a.valid) return 1'b0;
        return min_mode ? (a.key < b.key) : (a.key > b.key);
    endfunction
endpackage

// File: rtl/register_tree_kv_if.sv
// Request/response bundle of the register-tree priority queue.
interface register_tree_kv_if #(
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 8,
    parameter int QUEUE_SIZE = 15
) ();
    logic                            i_enq;
    logic                            i_deq;
    logic [KEY_WIDTH-1:0]            i_key;
    logic [VAL_WIDTH-1:0]            i_val;
    logic                            o_top_valid;
    logic [KEY_WIDTH-1:0]            o_top_key;
    logic [VAL_WIDTH-1:0]            o_top_val;
    logic [$clog2(QUEUE_SIZE+1)-1:0] o_count;
    logic                            o_full;
    logic                            o_empty;

    modport master (
        output i_enq, i_deq, i_key, i_val,
        input  o_top_valid, o_top_key, o_top_val, o_count, o_full, o_empty
    );
    modport slave (
        input  i_enq, i_deq, i_key, i_val,
        output o_top_valid, o_top_key, o_top_val, o_count, o_full, o_empty
    );
endinterface

// File: rtl/rt_cas_node.sv
// Combinational compare-and-swap of one parent against its two children.
module rt_cas_node
    import register_tree_pkg::*;
#(
    parameter bit MIN_MODE = 1'b0
) (
    input  logic     en,
    input  rt_node_t p,
    input  rt_node_t l,
    input  rt_node_t r,
    output rt_node_t p_o,
    output rt_node_t l_o,
    output rt_node_t r_o
);
    logic     pick_r;
    rt_node_t win;

    always_comb begin
        pick_r = rt_outranks(r, l, MIN_MODE);
        win    = pick_r ? r : l;
        p_o    = p;
        l_o    = l;
        r_o    = r;
        if (en && rt_outranks(win, p, MIN_MODE)) begin
            p_o = win;
            if (pick_r) r_o = p;
            else        l_o = p;
        end
    end
endmodule

// File: rtl/register_tree_kv.sv
// Register-tree priority queue: O(1) enqueue/dequeue/replace, with the heap
// order restored over idle cycles by alternating even/odd-level compare-swaps.
module register_tree_kv
    import register_tree_pkg::*;
#(
    parameter int QUEUE_SIZE = 15,
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 8,
    parameter int MIN_MODE   = 0
) (
    input logic               i_CLK,
    input logic               i_RSTn,
    register_tree_kv_if.slave bus
);
    localparam int NODES = (1 << $clog2(QUEUE_SIZE + 1)) - 1;
    localparam int INT_N = (NODES - 1) / 2;
    localparam int CW    = $clog2(QUEUE_SIZE + 1);
    localparam int IW    = $clog2(NODES);

    rt_node_t         q     [NODES];
    rt_node_t         nxt   [NODES];
    rt_node_t         p_o   [INT_N];
    rt_node_t         l_o   [INT_N];
    rt_node_t         r_o   [INT_N];
    logic [INT_N-1:0] en;
    logic             phase;
    logic [CW-1:0]    count;
    logic [IW-1:0]    free_idx;
    rt_node_t         new_n;
    logic             full, empty, do_enq, do_deq, do_rep, idle;

    assign full   = (count == CW'(QUEUE_SIZE));
    assign empty  = (count == '0);
    assign do_enq = bus.i_enq && !bus.i_deq && !full;
    assign do_deq = bus.i_deq && !bus.i_enq && !empty;
    assign do_rep = bus.i_enq && bus.i_deq;
    assign idle   = !(do_enq || do_deq || do_rep);

    // Same-parity parents never share a node, so their swaps can all land in one cycle.
    for (genvar g = 0; g < INT_N; g++) begin : g_cas
        localparam int LVL = $clog2(g + 2) - 1;
        localparam bit ODD = (LVL % 2) == 1;
        assign en[g] = idle && (phase == ODD);
        rt_cas_node #(.MIN_MODE(MIN_MODE != 0)) u_cas (
            .en (en[g]),
            .p  (q[g]),
            .l  (q[2*g+1]),
            .r  (q[2*g+2]),
            .p_o(p_o[g]),
            .l_o(l_o[g]),
            .r_o(r_o[g])
        );
    end

    always_comb begin
        new_n = '0;
        new_n.valid = 1'b1;
        new_n.key[KEY_WIDTH-1:0] = bus.i_key;
        new_n.val[VAL_WIDTH-1:0] = bus.i_val;
        free_idx = '0;
        for (int i = NODES - 1; i >= 0; i--)
            if (!q[i].valid) free_idx = IW'(i);
    end

    always_comb begin
        nxt = q;
        if (do_enq) begin
            nxt[free_idx] = new_n;
        end else if (do_deq) begin
            nxt[0].valid = 1'b0;
        end else if (do_rep) begin
            nxt[0] = new_n;
        end else begin
            for (int i = 0; i < INT_N; i++) begin
                if (en[i]) begin
                    nxt[i]     = p_o[i];
                    nxt[2*i+1] = l_o[i];
                    nxt[2*i+2] = r_o[i];
                end
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            for (int i = 0; i < NODES; i++) q[i] <= '0;
            count <= '0;
            phase <= 1'b0;
        end else begin
            q <= nxt;
            if (do_enq || (do_rep && !q[0].valid)) count <= count + CW'(1);
            else if (do_deq)                       count <= count - CW'(1);
            phase <= idle ? ~phase : 1'b0;
        end
    end

    assign bus.o_top_valid = q[0].valid;
    assign bus.o_top_key   = q[0].key[KEY_WIDTH-1:0];
    assign bus.o_top_val   = q[0].val[VAL_WIDTH-1:0];
    assign bus.o_count     = count;
    assign bus.o_full      = full;
    assign bus.o_empty     = empty;
endmodule

// File: doc/register_tree_kv.md
REGISTER_TREE_KV -- requirements
Module: register_tree_kv

Interface
REQ-001 Parameter QUEUE_SIZE, default 15, meaning maximum number of stored entries (>=3).
REQ-002 Parameter KEY_WIDTH, default 16, meaning priority key width.
REQ-003 Parameter VAL_WIDTH, default 8, meaning payload width carried with each key.
REQ-004 Parameter MIN_MODE, default 0, meaning 0 = largest key at root, 1 = smallest key at root.
REQ-005 i_CLK  in  1  the single clock; synchronous reset is active-low, sampled on its rising edge.
REQ-006 i_RSTn  in  1  synchronous active-low reset.
REQ-007 i_enq  in  1  insert request.
REQ-008 i_deq  in  1  remove-root request; i_enq and i_deq both high means replace.
REQ-009 i_key  in  KEY_WIDTH  key for insert/replace.
REQ-010 i_val  in  VAL_WIDTH  payload for insert/replace.
REQ-011 o_top_valid  out  1  root node holds a valid entry.
REQ-012 o_top_key / o_top_val  out  KEY_WIDTH / VAL_WIDTH  root key and payload, registered.
REQ-013 o_count  out  $clog2(QUEUE_SIZE+1)  number of valid entries.
REQ-014 o_full / o_empty  out  1  count == QUEUE_SIZE / count == 0.

Function
REQ-015 Storage: NODES = 2^ceil(log2(QUEUE_SIZE+1)) - 1 nodes, each {valid, key, val}; node i has children 2i+1, 2i+2.
REQ-016 Emptiness is marked by per-node valid bit only; key value 0 is a legal key.
REQ-017 Priority order: valid beats invalid; among valid, greater key wins (MIN_MODE=0) or smaller key wins (MIN_MODE=1); equal keys -> no swap, left child preferred over right.
REQ-018 Enqueue (i_enq & !i_deq & !full): write entry into lowest-index invalid node; count+1; no compare-swap this cycle.
REQ-019 Enqueue while full: ignored, no state change.
REQ-020 Dequeue (i_deq & !i_enq & !empty): invalidate node 0; count-1; no compare-swap this cycle.
REQ-021 Dequeue while empty: ignored.
REQ-022 Replace (both high): write entry into node 0, set valid; count+1 if root was invalid, else unchanged; no compare-swap this cycle.
REQ-023 Idle cycle: one compare-swap phase; even phase acts on parents at even levels, odd phase on odd levels; each active parent swaps with winning child when child outranks it.
REQ-024 Phase flag: set to even after any accepted operation; toggles every idle cycle; ignored operations count as idle.
REQ-025 Ordering guarantee: after 2*ceil(log2(NODES+1)) consecutive idle cycles, root holds highest-priority valid entry and every valid parent outranks its children.
REQ-026 o_top_* reflect node 0 registered state; o_top_valid may be low transiently after dequeue while count>0.
REQ-027 Key and payload always move together; payload never affects ordering.

Reset
REQ-028 On i_RSTn low at rising edge: all valid bits 0, keys/payloads 0, count 0, phase even.
REQ-029 Outputs after reset: o_top_valid 0, o_top_key 0, o_top_val 0, o_count 0, o_empty 1, o_full 0.
REQ-030 Reset overrides any simultaneous i_enq/i_deq; reset mid-sort discards all contents.

Structure
REQ-031 Package register_tree_pkg holds the node struct typedef (valid, key, val) parameterised via widths and a priority-compare function taking MIN_MODE.
REQ-032 One sub-module rt_cas_node: combinational compare-and-swap of one parent and two children, instantiated per internal node and enabled by level parity.
REQ-033 All queue state is in one always_ff with synchronous reset.

Verification
REQ-034 Reset, then 5 idle cycles -> o_empty 1, o_top_valid 0, o_count 0.
REQ-035 MIN_MODE=0: enqueue keys 3,9,0,7 back-to-back, 8 idle cycles -> o_top_key 9, o_count 4; dequeues with 8 idle between -> 9,7,3,0, then o_empty 1.
REQ-036 MIN_MODE=1, payload = key+100: enqueue 5,2,8, settle, replace with key 6 -> top key 2 val 102 before, then 5 val 105 after settle, count 3.
REQ-037 Fill QUEUE_SIZE=15 entries, then enqueue key 999 -> o_full 1, count stays 15, 999 never reaches root.
REQ-038 Dequeue when empty and replace when empty (key 4) -> first ignored; second gives o_top_valid 1, key 4, count 1 next cycle.
REQ-039 Assert i_RSTn low mid-sort with 6 entries -> next cycle all outputs at REQ-029 values.
